bus_sram_responder: RTL and testbench

Burst-capable bus target (responder) for the shared system bus driven by ramDmaCi and the CPU. It decodes a single-cycle transaction start, then either streams words out of a local SRAM for reads or absorbs words into it for writes. It signals errors for out-of-range or misaligned addresses. Its programmable write back-pressure lets DMA write paths be exercised against a real target.

---
 rtl/bus_pkg.sv | 42 ++++
 rtl/bus_sram_responder_if.sv | 40 ++++
 rtl/bus_sram.sv | 47 ++++
 rtl/bus_sram_responder.sv | 188 ++++++++++++++++++
 tb/tb_bus_sram_responder.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the burst SRAM bus responder:
//   - responder FSM state encoding
//   - bus field widths (data, burst size, byte enables)
//   - burst length helper (burst field encodes words minus one)
//   - address decode helper for a base-aligned SRAM window
// -----------------------------------------------------------------------------
package bus_pkg;

    localparam int DATA_W  = 32;
    localparam int BURST_W = 8;
    localparam int BE_W    = 4;
    // One bit wider than the burst field so a 256-word burst is representable.
    localparam int CNT_W   = BURST_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_PREFETCH,
        ST_RD_BURST,
        ST_RD_END,
        ST_WR,
        ST_ERR
    } state_e;

    // Number of words in a burst (BURST_WORDS = burstSize + 1).
    function automatic logic [CNT_W-1:0] burst_words(input logic [BURST_W-1:0] burst_size);
        return {1'b0, burst_size} + 9'd1;
    endfunction

    // Hit when addr lies inside the 4*2**aw byte window starting at base and is
    // word aligned. base is aligned to the window size, so comparing the bits
    // above the window is the same as a full range check and cannot overflow.
    function automatic logic addr_hit(input logic [DATA_W-1:0] addr,
                                      input logic [DATA_W-1:0] base,
                                      input int                aw);
        logic [DATA_W-1:0] mask;
        mask = ~((32'd1 << (aw + 2)) - 32'd1);
        return ((addr & mask) == (base & mask)) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/bus_sram_responder_if.sv
// -----------------------------------------------------------------------------
// bus_sram_responder_if
// Shared system bus as seen by one responder.
//   Initiator -> responder: beginTransactionIn, addressDataIn, burstSizeIn,
//                           readNotWriteIn, byteEnablesIn, dataValidIn,
//                           endTransactionIn
//   Responder -> initiator: addressDataOut, dataValidOut, endTransactionOut,
//                           busErrorOut, busyOut
// master modport: the initiator side; slave modport: the responder side.
// -----------------------------------------------------------------------------
interface bus_sram_responder_if;
    import bus_pkg::*;

    logic               beginTransactionIn;
    logic [DATA_W-1:0]  addressDataIn;
    logic [BURST_W-1:0] burstSizeIn;
    logic               readNotWriteIn;
    logic [BE_W-1:0]    byteEnablesIn;
    logic               dataValidIn;
    logic               endTransactionIn;

    logic [DATA_W-1:0]  addressDataOut;
    logic               dataValidOut;
    logic               endTransactionOut;
    logic               busErrorOut;
    logic               busyOut;

    modport master (
        output beginTransactionIn, addressDataIn, burstSizeIn, readNotWriteIn,
               byteEnablesIn, dataValidIn, endTransactionIn,
        input  addressDataOut, dataValidOut, endTransactionOut, busErrorOut, busyOut
    );

    modport slave (
        input  beginTransactionIn, addressDataIn, burstSizeIn, readNotWriteIn,
               byteEnablesIn, dataValidIn, endTransactionIn,
        output addressDataOut, dataValidOut, endTransactionOut, busErrorOut, busyOut
    );

endinterface

// File: rtl/bus_sram.sv
// -----------------------------------------------------------------------------
// bus_sram
// Single-port 2**ADDR_WIDTH x 32 SRAM, per-byte write enables, synchronous
// read with one cycle of latency.
//   clk_i    clock
//   en_i     access enable
//   be_i     byte write enables; all zero with en_i high means a read
//   addr_i   word address
//   wdata_i  write data
//   rdata_o  read data, valid the cycle after a read access
// -----------------------------------------------------------------------------
module bus_sram
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic [BE_W-1:0]       be_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the array has no reset so it maps onto a RAM macro; contents
    // survive a bus reset.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (be_i == '0) begin
                rdata_q <= mem_q[addr_i];
            end
            for (int b = 0; b < BE_W; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_sram_responder.sv
// -----------------------------------------------------------------------------
// bus_sram_responder
// Burst-capable bus target backed by a local SRAM. A one-cycle begin strobe
// selects a read burst (words streamed out, then a one-cycle end strobe), a
// write burst (words absorbed until the initiator ends), or an error (decode
// miss / misaligned address, one-cycle error strobe). Optional write
// back-pressure inserts a busy cycle after every WRITE_STALL written words.
//   clock   system clock, rising edge
//   reset   synchronous, active-high
//   bus     responder side of the system bus (slave modport)
// All bus outputs are registered and cleared by reset.
// -----------------------------------------------------------------------------
module bus_sram_responder
    import bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
    parameter int          ADDR_WIDTH   = 10,
    parameter int          WRITE_STALL  = 0
) (
    input  logic clock,
    input  logic reset,
    bus_sram_responder_if.slave bus
);

    localparam logic [15:0] STALL_N = 16'(WRITE_STALL);

    state_e                 state_q;
    logic [ADDR_WIDTH-1:0]  wptr_q, wptr_d;
    logic [CNT_W-1:0]       left_q;        // words still to stream / accept
    logic                   rnw_q;
    logic [1:0]             err_phase_q;   // cycles spent in ERR, saturates at 2
    logic                   err_end_q;     // endTransactionIn seen before the strobe
    logic [15:0]            stall_cnt_q;

    logic [DATA_W-1:0]      rdata_out_q;
    logic                   dv_q, endt_q, berr_q, busy_q;

    logic                   begin_hit;
    logic [ADDR_WIDTH-1:0]  begin_wptr;
    logic                   rd_issue, wr_do, stall_hit;
    logic                   sram_en;
    logic [BE_W-1:0]        sram_be;
    logic [DATA_W-1:0]      sram_rdata;

    assign begin_hit  = addr_hit(bus.addressDataIn, BASE_ADDRESS, ADDR_WIDTH);
    assign begin_wptr = bus.addressDataIn[ADDR_WIDTH+1:2];
    assign stall_hit  = (STALL_N != 16'd0) && (stall_cnt_q == STALL_N - 16'd1);

    // NOTE: every signal driven here gets a value on every path (defaults
    // first), so no latches are inferred.
    always_comb begin
        rd_issue = 1'b0;
        wr_do    = 1'b0;
        // Reads are issued every cycle of the burst; the surplus reads after
        // the last word are harmless and keep the pipeline simple.
        rd_issue = (state_q == ST_RD_PREFETCH) || (state_q == ST_RD_BURST);
        // busyOut being high means the word on the bus is held, not taken.
        // Words past the burst length are taken but dropped.
        wr_do    = (state_q == ST_WR) && bus.dataValidIn && !busy_q && (left_q != '0);
        sram_en  = rd_issue || wr_do;
        sram_be  = wr_do ? bus.byteEnablesIn : '0;
        // Pointer wraps modulo DEPTH by natural overflow.
        wptr_d   = sram_en ? wptr_q + 1'b1 : wptr_q;
    end

    bus_sram #(.ADDR_WIDTH(ADDR_WIDTH)) u_sram (
        .clk_i   (clock),
        .en_i    (sram_en),
        .be_i    (sram_be),
        .addr_i  (wptr_q),
        .wdata_i (bus.addressDataIn),
        .rdata_o (sram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wptr_q      <= '0;
            left_q      <= '0;
            rnw_q       <= 1'b0;
            err_phase_q <= '0;
            err_end_q   <= 1'b0;
            stall_cnt_q <= '0;
            rdata_out_q <= '0;
            dv_q        <= 1'b0;
            endt_q      <= 1'b0;
            berr_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // Strobes and read data default low every cycle.
            rdata_out_q <= '0;
            dv_q        <= 1'b0;
            endt_q      <= 1'b0;
            berr_q      <= 1'b0;
            busy_q      <= 1'b0;
            wptr_q      <= wptr_d;

            case (state_q)
                ST_IDLE: begin
                    if (bus.beginTransactionIn) begin
                        wptr_q      <= begin_wptr;
                        left_q      <= burst_words(bus.burstSizeIn);
                        rnw_q       <= bus.readNotWriteIn;
                        err_phase_q <= '0;
                        err_end_q   <= 1'b0;
                        stall_cnt_q <= '0;
                        if (!begin_hit) begin
                            state_q <= ST_ERR;
                        end else if (bus.readNotWriteIn) begin
                            state_q <= ST_RD_PREFETCH;
                        end else begin
                            state_q <= ST_WR;
                        end
                    end
                end

                // First SRAM read is in flight; its data appears next cycle.
                ST_RD_PREFETCH: begin
                    state_q <= ST_RD_BURST;
                end

                ST_RD_BURST: begin
                    dv_q        <= 1'b1;
                    rdata_out_q <= sram_rdata;
                    left_q      <= left_q - 1'b1;
                    if (left_q == 9'd1) begin
                        state_q <= ST_RD_END;
                    end
                end

                ST_RD_END: begin
                    endt_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end

                ST_WR: begin
                    if (wr_do) begin
                        left_q <= left_q - 1'b1;
                        if (stall_hit) begin
                            stall_cnt_q <= '0;
                            // No busy cycle once the transaction is over.
                            busy_q      <= !bus.endTransactionIn;
                        end else begin
                            stall_cnt_q <= stall_cnt_q + 16'd1;
                        end
                    end
                    if (bus.endTransactionIn) begin
                        state_q <= ST_IDLE;
                    end
                end

                // Error strobe lands two cycles after begin; a write error
                // then waits for the initiator to end, remembering an early end.
                ST_ERR: begin
                    case (err_phase_q)
                        2'd0: begin
                            err_phase_q <= 2'd1;
                            err_end_q   <= !rnw_q && bus.endTransactionIn;
                        end
                        2'd1: begin
                            berr_q      <= 1'b1;
                            err_phase_q <= 2'd2;
                            if (rnw_q || err_end_q || bus.endTransactionIn) begin
                                state_q <= ST_IDLE;
                            end
                        end
                        default: begin
                            if (bus.endTransactionIn) begin
                                state_q <= ST_IDLE;
                            end
                        end
                    endcase
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.addressDataOut    = rdata_out_q;
    assign bus.dataValidOut      = dv_q;
    assign bus.endTransactionOut = endt_q;
    assign bus.busErrorOut       = berr_q;
    assign bus.busyOut           = busy_q;

endmodule

// File: tb/tb_bus_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_bus_sram_responder
// Directed stimulus for bus_sram_responder. Drivers push the expected output
// events (cycle + output values) into a queue; a monitor on the falling edge
// pops and compares whenever any output is non-zero.
// -----------------------------------------------------------------------------
module tb_bus_sram_responder;

    localparam logic [31:0] BASE  = 32'h5000_0000;
    localparam int          AW    = 10;
    localparam int          DEPTH = 1024;
    localparam int          STALL = 2;

    typedef struct {
        int          tag;
        int          cyc;
        logic [35:0] outv;   // {busy, berr, endt, dv, data}
    } exp_t;

    logic  clk;
    logic  rst;
    int    cyc = 0;
    int    nvec = 0;
    int    miscomp = 0;
    exp_t  exp_q[$];
    exp_t  mon_e;
    exp_t  left_e;
    logic [35:0] mon_out;
    logic [31:0] wbuf [16];
    logic [31:0] rbuf [16];

    bus_sram_responder_if bus_if ();

    bus_sram_responder #(
        .BASE_ADDRESS (BASE),
        .ADDR_WIDTH   (AW),
        .WRITE_STALL  (STALL)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            miscomp++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] cur_outputs();
        return {bus_if.busyOut, bus_if.busErrorOut, bus_if.endTransactionOut,
                bus_if.dataValidOut, bus_if.addressDataOut};
    endfunction

    task automatic expect_out(input int tag, input int c, input logic dv, input logic endt,
                              input logic berr, input logic busy, input logic [31:0] d);
        exp_t e;
        e.tag  = tag;
        e.cyc  = c;
        e.outv = {busy, berr, endt, dv, d};
        exp_q.push_back(e);
    endtask

    // Monitor: any non-zero output is an event that must match the queue head.
    always @(negedge clk) begin
        mon_out = cur_outputs();
        if (mon_out != '0) begin
            if (exp_q.size() == 0) begin
                check($sformatf("unexpected_output_cycle%0d", cyc), 64'(mon_out), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("ev%0d_cycle", mon_e.tag), 64'(cyc), 64'(mon_e.cyc));
                check($sformatf("ev%0d_outputs", mon_e.tag), 64'(mon_out), 64'(mon_e.outv));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.beginTransactionIn = 1'b0;
        bus_if.addressDataIn      = '0;
        bus_if.burstSizeIn        = '0;
        bus_if.readNotWriteIn     = 1'b0;
        bus_if.byteEnablesIn      = '0;
        bus_if.dataValidIn        = 1'b0;
        bus_if.endTransactionIn   = 1'b0;
    endtask

    // Drives the begin strobe; t is the edge at which it is sampled.
    task automatic do_begin(input logic [31:0] addr, input int burst, input logic rnw, output int t);
        bus_if.beginTransactionIn = 1'b1;
        bus_if.addressDataIn      = addr;
        bus_if.burstSizeIn        = 8'(burst);
        bus_if.readNotWriteIn     = rnw;
        t = cyc + 1;
        tick();
        clear_inputs();
    endtask

    // Read of burst+1 words expected to equal rbuf[0..burst], or an error.
    task automatic read_burst(input int tag, input logic [31:0] addr, input int burst, input logic err);
        int t;
        do_begin(addr, burst, 1'b1, t);
        if (err) begin
            expect_out(tag, t + 2, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
            repeat (2) tick();
        end else begin
            for (int k = 0; k <= burst; k++)
                expect_out(tag + k, t + 2 + k, 1'b1, 1'b0, 1'b0, 1'b0, rbuf[k]);
            expect_out(tag + 99, t + 3 + burst, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
            repeat (burst + 3) tick();
        end
    endtask

    // Write of nwords from wbuf, endTransactionIn with the last word. The bench
    // predicts busy cycles itself and holds the next word through each one.
    task automatic write_burst(input int tag, input logic [31:0] addr, input int burst,
                               input int nwords, input logic [3:0] be, input logic err);
        int   t;
        int   cnt;
        logic hold;
        do_begin(addr, burst, 1'b0, t);
        if (err) expect_out(tag, t + 2, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        cnt  = 0;
        hold = 1'b0;
        for (int i = 0; i < nwords; i++) begin
            bus_if.dataValidIn      = 1'b1;
            bus_if.addressDataIn    = wbuf[i];
            bus_if.byteEnablesIn    = be;
            bus_if.endTransactionIn = (i == nwords - 1);
            if (hold) begin
                tick();
                hold = 1'b0;
            end
            tick();
            if (!err && i <= burst) begin
                cnt++;
                if (cnt == STALL) begin
                    cnt = 0;
                    if (i != nwords - 1) begin
                        expect_out(tag + 50 + i, cyc, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
                        hold = 1'b1;
                    end
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        int t;
        rst = 1'b1;
        clear_inputs();
        repeat (3) tick();
        check("reset_outputs", 64'(cur_outputs()), 64'd0);
        rst = 1'b0;
        tick();

        // Single-word read of word 3.
        wbuf[0] = 32'hDEAD_BEEF;
        write_burst(100, BASE + 32'd12, 0, 1, 4'hF, 1'b0);
        rbuf[0] = 32'hDEAD_BEEF;
        read_burst(110, BASE + 32'd12, 0, 1'b0);

        // Burst crossing the top of the array wraps to word 0 (write and read).
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0DE_0000 + 32'(i);
        write_burst(200, BASE + 32'(4 * (DEPTH - 2)), 3, 4, 4'hF, 1'b0);
        for (int i = 0; i < 4; i++) rbuf[i] = 32'hC0DE_0000 + 32'(i);
        read_burst(210, BASE + 32'(4 * (DEPTH - 2)), 3, 1'b0);

        // Byte-enable merge into a cleared word 5.
        wbuf[0] = 32'h0000_0000;
        write_burst(300, BASE + 32'd20, 0, 1, 4'hF, 1'b0);
        wbuf[0] = 32'h1122_3344;
        write_burst(310, BASE + 32'd20, 0, 1, 4'b0101, 1'b0);
        rbuf[0] = 32'h0022_0044;
        read_burst(320, BASE + 32'd20, 0, 1'b0);

        // Six-word write with back-pressure after words 2 and 4.
        for (int i = 0; i < 6; i++) wbuf[i] = 32'(10 * (i + 1));
        write_burst(400, BASE, 5, 6, 4'hF, 1'b0);
        for (int i = 0; i < 6; i++) rbuf[i] = 32'(10 * (i + 1));
        read_burst(410, BASE, 5, 1'b0);

        // Words beyond the burst length are dropped.
        wbuf[0] = 32'h0000_0077;
        wbuf[1] = 32'h0000_0088;
        write_burst(500, BASE + 32'd28, 1, 2, 4'hF, 1'b0);
        wbuf[0] = 32'hAAAA_0007;
        wbuf[1] = 32'hBBBB_0008;
        write_burst(510, BASE + 32'd28, 0, 2, 4'hF, 1'b0);
        rbuf[0] = 32'hAAAA_0007;
        rbuf[1] = 32'h0000_0088;
        read_burst(520, BASE + 32'd28, 1, 1'b0);

        // Out-of-range read, misaligned write, memory untouched afterwards.
        read_burst(600, BASE + 32'(4 * DEPTH), 0, 1'b1);
        for (int i = 0; i < 3; i++) wbuf[i] = 32'hFFFF_FFFF;
        write_burst(610, BASE + 32'd2, 2, 3, 4'hF, 1'b1);
        rbuf[0] = 32'd10;
        read_burst(620, BASE, 0, 1'b0);

        // Reset while word 2 of an 8-word read is on the bus.
        do_begin(BASE, 7, 1'b1, t);
        for (int k = 0; k < 3; k++)
            expect_out(700 + k, t + 2 + k, 1'b1, 1'b0, 1'b0, 1'b0, 32'(10 * (k + 1)));
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("reset_mid_burst_outputs", 64'(cur_outputs()), 64'd0);
        rst = 1'b0;
        rbuf[0] = 32'd50;
        read_burst(710, BASE + 32'd16, 0, 1'b0);

        repeat (5) tick();
        while (exp_q.size() > 0) begin
            left_e = exp_q.pop_front();
            check($sformatf("ev%0d_missing", left_e.tag), 64'd0, 64'(left_e.outv));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, miscomp);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
